// File: rtl/spi_frame_loader_if.sv
// SPI pins plus LED memory write port of the frame loader.
// Signals:
//   spi_sclk, spi_mosi, spi_cs_n : SPI mode 0 pins driven by the host.
//   perform_write                : one-cycle memory write strobe.
//   write_address                : LED memory address (ADDR_WIDTH bits).
//   write_data                   : 24-bit pixel word.
//   frame_done, error            : one-cycle status pulses.
// Modports:
//   master : host/consumer side (drives SPI, observes writes and status).
//   slave  : the frame loader itself.
interface spi_frame_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_cs_n;
    logic                  perform_write;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [23:0]           write_data;
    logic                  frame_done;
    logic                  error;

    modport master (
        output spi_sclk, spi_mosi, spi_cs_n,
        input  perform_write, write_address, write_data, frame_done, error
    );

    modport slave (
        input  spi_sclk, spi_mosi, spi_cs_n,
        output perform_write, write_address, write_data, frame_done, error
    );
endinterface

// File: rtl/spi_frame_loader.sv
// SPI slave (mode 0, MSB first) that loads LED pixel triples into the LED
// memory write port. A transaction is a start index byte followed by 24-bit
// triples; each complete triple becomes one write at an auto-incrementing
// address that wraps at LED_COUNT.
// Ports:
//   clock_12mhz : the only clock; SPI pins are oversampled in this domain.
//   reset_n     : asynchronous active-low reset.
//   bus         : spi_frame_loader_if.slave (SPI pins in, write port and
//                 frame_done/error pulses out).
// Build option:
//   RGB_TO_GRB_EN : when defined, write_data = {slot1, slot0, slot2} so the
//                   host can send RGB while the strip sees GRB order.
//                   When undefined, bytes are written in received order.
module spi_frame_loader #(
    parameter int LED_COUNT   = 256,
    parameter int ADDR_WIDTH  = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock_12mhz,
    input  logic           reset_n,
    spi_frame_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, PIXEL, DISCARD} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LED_COUNT - 1);
    localparam logic [ADDR_WIDTH:0]   IDX_LIMIT = (ADDR_WIDTH + 1)'(LED_COUNT);

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, cs_rise, cs_fall, shift_en, byte_done;
    logic [7:0]             shreg, byte_val;
    logic [2:0]             bit_cnt, cnt_step;
    logic [1:0]             slot, slot_nx;
    logic [7:0]             pix0, pix1, pix2;
    logic [23:0]            pix_word;
    logic [ADDR_WIDTH-1:0]  addr_cnt;
    logic                   idx_ok;
    logic                   wr_pend;
    logic                   load_addr, fill_slot, wr_set, done_set, err_set, clr_cnt;

    // Input synchronisers, reset to the idle bus levels.
    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;
    // Qualify with the previous cs sample so an sclk edge landing in the
    // same cycle as the cs_n rise is still shifted in before the deassert.
    assign shift_en  = sclk_rise & ~cs_q;
    assign byte_done = shift_en & (bit_cnt == 3'd7);
    assign byte_val  = {shreg[6:0], mosi_s};
    assign cnt_step  = shift_en ? bit_cnt + 3'd1 : bit_cnt;
    assign idx_ok    = (ADDR_WIDTH + 1)'(byte_val) < IDX_LIMIT;

`ifdef RGB_TO_GRB_EN
    assign pix_word = {pix1, pix0, pix2};
`else
    assign pix_word = {pix0, pix1, pix2};
`endif

    always_comb begin
        state_nx  = state;
        slot_nx   = slot;
        load_addr = 1'b0;
        fill_slot = 1'b0;
        wr_set    = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    clr_cnt  = 1'b1;
                    slot_nx  = 2'd0;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                if (byte_done) begin
                    if (idx_ok) begin
                        load_addr = 1'b1;
                        slot_nx   = 2'd0;
                        state_nx  = PIXEL;
                        // Index alone then deassert: no partial triple.
                        if (cs_rise) begin
                            done_set = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        err_set  = 1'b1;
                        state_nx = cs_rise ? IDLE : DISCARD;
                    end
                end else if (cs_rise) begin
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end
            end
            PIXEL: begin
                if (byte_done) begin
                    fill_slot = 1'b1;
                    if (slot == 2'd2) begin
                        wr_set  = 1'b1;
                        slot_nx = 2'd0;
                    end else begin
                        slot_nx = slot + 2'd1;
                    end
                end
                // Judged on the post-edge slot/bit position.
                if (cs_rise) begin
                    state_nx = IDLE;
                    if (slot_nx == 2'd0 && cnt_step == 3'd0) done_set = 1'b1;
                    else                                     err_set  = 1'b1;
                end
            end
            DISCARD: begin
                if (cs_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            slot     <= 2'd0;
            pix0     <= 8'd0;
            pix1     <= 8'd0;
            pix2     <= 8'd0;
            addr_cnt <= '0;
            wr_pend  <= 1'b0;
        end else begin
            state   <= state_nx;
            slot    <= slot_nx;
            bit_cnt <= clr_cnt ? 3'd0 : cnt_step;
            wr_pend <= wr_set;
            if (shift_en) shreg <= byte_val;
            if (fill_slot) begin
                case (slot)
                    2'd0:    pix0 <= byte_val;
                    2'd1:    pix1 <= byte_val;
                    default: pix2 <= byte_val;
                endcase
            end
            if (load_addr)    addr_cnt <= ADDR_WIDTH'(byte_val);
            else if (wr_pend) addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 1'b1;
        end
    end

    // Registered outputs; address/data hold their last written values.
    always_ff @(posedge clock_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            bus.perform_write <= 1'b0;
            bus.write_address <= '0;
            bus.write_data    <= 24'd0;
            bus.frame_done    <= 1'b0;
            bus.error         <= 1'b0;
        end else begin
            bus.perform_write <= wr_pend;
            bus.frame_done    <= done_set;
            bus.error         <= err_set;
            if (wr_pend) begin
                bus.write_address <= addr_cnt;
                bus.write_data    <= pix_word;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
`timescale 1ns/1ps
module tb_spi_frame_loader;
    localparam int SYNC  = 2;
    localparam int AW    = 9;
    localparam int CLK_P = 84;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    always #(CLK_P/2) clk = ~clk;

    // Two instances see the same SPI traffic: a full 256-LED strip and a
    // 100-LED strip so out-of-range indices can be exercised.
    spi_frame_loader_if #(.ADDR_WIDTH(AW)) bus_a ();
    spi_frame_loader_if #(.ADDR_WIDTH(AW)) bus_b ();
    assign bus_a.spi_sclk = sclk;
    assign bus_a.spi_mosi = mosi;
    assign bus_a.spi_cs_n = cs_n;
    assign bus_b.spi_sclk = sclk;
    assign bus_b.spi_mosi = mosi;
    assign bus_b.spi_cs_n = cs_n;

    spi_frame_loader #(.LED_COUNT(256), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC)) dut_a (
        .clock_12mhz(clk), .reset_n(rst_n), .bus(bus_a.slave));
    spi_frame_loader #(.LED_COUNT(100), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC)) dut_b (
        .clock_12mhz(clk), .reset_n(rst_n), .bus(bus_b.slave));

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: only this process writes the observed-event records.
    logic [32:0] got_w[2][$];
    time         got_t[$];
    int          done_cnt[2], err_cnt[2];
    int          wide_cnt = 0, both_cnt = 0;
    logic        pw_q[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        logic        pw[2], fd[2], er[2];
        logic [32:0] wd[2];
        pw[0] = bus_a.perform_write; fd[0] = bus_a.frame_done; er[0] = bus_a.error;
        pw[1] = bus_b.perform_write; fd[1] = bus_b.frame_done; er[1] = bus_b.error;
        wd[0] = {bus_a.write_address, bus_a.write_data};
        wd[1] = {bus_b.write_address, bus_b.write_data};
        for (int d = 0; d < 2; d++) begin
            if (pw[d]) begin
                got_w[d].push_back(wd[d]);
                if (d == 0) got_t.push_back($time);
                if (pw_q[d]) wide_cnt++;
            end
            if (fd[d]) done_cnt[d]++;
            if (er[d]) err_cnt[d]++;
            if (fd[d] && er[d]) both_cnt++;
            pw_q[d] = pw[d];
        end
    end

    // Reference model: derives the transaction outcome from the bit list.
    bit          tx_bits[$];
    time         rise_t[$];
    logic [32:0] exp_w[2][$];
    int          exp_done[2], exp_err[2];
    int          base_w[2], base_done[2], base_err[2], base_t;

    function automatic void add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endfunction

    function automatic logic [7:0] get_byte(input int pos);
        logic [7:0] v = 8'd0;
        for (int i = 0; i < 8; i++) v = {v[6:0], logic'(tx_bits[pos + i])};
        return v;
    endfunction

    function automatic void model(input int d, input int lc);
        int n = tx_bits.size();
        int idx;
        logic [7:0] s0, s1, s2;
        logic [23:0] data;
        exp_w[d].delete();
        exp_done[d] = 0;
        exp_err[d]  = 0;
        if (n < 8) begin exp_err[d] = 1; return; end
        idx = int'(get_byte(0));
        if (idx >= lc) begin exp_err[d] = 1; return; end
        for (int k = 0; k < (n - 8) / 24; k++) begin
            s0 = get_byte(8 + 24*k);
            s1 = get_byte(16 + 24*k);
            s2 = get_byte(24 + 24*k);
`ifdef RGB_TO_GRB_EN
            data = {s1, s0, s2};
`else
            data = {s0, s1, s2};
`endif
            exp_w[d].push_back({AW'((idx + k) % lc), data});
        end
        if ((n - 8) % 24 != 0) exp_err[d] = 1;
        else                   exp_done[d] = 1;
    endfunction

    task automatic mark();
        for (int d = 0; d < 2; d++) begin
            base_w[d]    = got_w[d].size();
            base_done[d] = done_cnt[d];
            base_err[d]  = err_cnt[d];
        end
        base_t = got_t.size();
    endtask

    task automatic check_txn(input string name);
        int n;
        for (int d = 0; d < 2; d++) begin
            n = got_w[d].size() - base_w[d];
            chk($sformatf("%s_d%0d_nwr", name, d), 64'(n), 64'(exp_w[d].size()));
            for (int i = 0; i < n && i < exp_w[d].size(); i++)
                chk($sformatf("%s_d%0d_wr%0d", name, d, i), 64'(got_w[d][base_w[d] + i]), 64'(exp_w[d][i]));
            chk($sformatf("%s_d%0d_done", name, d), 64'(done_cnt[d] - base_done[d]), 64'(exp_done[d]));
            chk($sformatf("%s_d%0d_err", name, d), 64'(err_cnt[d] - base_err[d]), 64'(exp_err[d]));
        end
    endtask

    task automatic xfer(input int ph);
        rise_t.delete();
        @(negedge clk); cs_n = 1'b0;
        repeat (ph) @(negedge clk);
        for (int i = 0; i < tx_bits.size(); i++) begin
            mosi = tx_bits[i];
            repeat (ph) @(negedge clk);
            sclk = 1'b1;
            if (i >= 8 && (i - 8) % 24 == 23) rise_t.push_back($time);
            repeat (ph) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (ph) @(negedge clk);
        cs_n = 1'b1; mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run(input string name, input int ph);
        mark();
        model(0, 256);
        model(1, 100);
        xfer(ph);
        check_txn(name);
    endtask

    initial begin
        #8ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, ph;
        repeat (3) @(negedge clk);
        chk("rst_pw",   64'(bus_a.perform_write), 64'(0));
        chk("rst_addr", 64'(bus_a.write_address), 64'(0));
        chk("rst_data", 64'(bus_a.write_data),    64'(0));
        chk("rst_done", 64'(bus_a.frame_done),    64'(0));
        chk("rst_err",  64'(bus_a.error),         64'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_bits.delete(); add_byte(8'h05); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33);
        run("basic", 4);

        tx_bits.delete(); add_byte(8'hFF);
        for (int i = 0; i < 6; i++) add_byte(8'(8'h40 + i));
        run("wrap", 3);

        tx_bits.delete(); add_byte(8'h10); add_byte(8'hDE); add_byte(8'hAD);
        run("partial", 4);

        tx_bits.delete(); add_byte(8'd100);
        for (int i = 0; i < 6; i++) add_byte(8'($urandom));
        run("idx100", 2);

        tx_bits.delete(); run("empty", 3);

        // Reset in the middle of the second pixel byte.
        mark();
        @(negedge clk); cs_n = 1'b0;
        repeat (3) @(negedge clk);
        tx_bits.delete(); add_byte(8'h03); add_byte(8'h5A); add_byte(8'hC3);
        for (int i = 0; i < 20; i++) begin
            mosi = tx_bits[i];
            repeat (3) @(negedge clk); sclk = 1'b1;
            repeat (3) @(negedge clk); sclk = 1'b0;
        end
        #10 rst_n = 1'b0;
        #1;
        chk("arst_pw",   64'(bus_a.perform_write), 64'(0));
        chk("arst_addr", 64'(bus_a.write_address), 64'(0));
        chk("arst_data", 64'(bus_a.write_data),    64'(0));
        chk("arst_b_data", 64'(bus_b.write_data),  64'(0));
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_w[d].delete(); exp_done[d] = 0; exp_err[d] = 0;
        end
        check_txn("abort");

        tx_bits.delete(); add_byte(8'h01); add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC);
        run("post_rst", 3);

        // 3 MHz sclk, three back-to-back triples, latency from the pin edge.
        tx_bits.delete(); add_byte(8'h07);
        for (int i = 0; i < 9; i++) add_byte(8'($urandom));
        run("fast", 2);
        for (int i = 0; i < 3; i++) begin
            if (base_t + i < got_t.size() && i < rise_t.size())
                chk($sformatf("lat%0d", i), 64'((got_t[base_t + i] - rise_t[i]) / CLK_P), 64'(SYNC + 2));
            else
                chk($sformatf("lat%0d_missing", i), 64'(0), 64'(1));
        end

        for (int t = 0; t < 25; t++) begin
            tx_bits.delete();
            kind = $urandom_range(0, 3);
            ph   = $urandom_range(2, 4);
            if (kind == 0) begin
                for (int i = $urandom_range(0, 60); i > 0; i--) tx_bits.push_back(bit'($urandom));
            end else begin
                add_byte(8'($urandom));
                for (int i = 3 * $urandom_range(0, 2); i > 0; i--) add_byte(8'($urandom));
            end
            run($sformatf("rnd%0d", t), ph);
        end

        chk("pulse_width", 64'(wide_cnt), 64'(0));
        chk("done_err_excl", 64'(both_cnt), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Upstream stage of the LED actor datapath; fills the LED memory write port, which is otherwise held low.
- Acts as an SPI slave (mode 0, MSB first) clocked entirely in the 12 MHz domain.
- Each transaction carries a start LED index followed by 24-bit pixel triples. Each completed triple becomes one memory write at an auto-incrementing address.
- Frame completion and protocol errors are reported as single-cycle pulses.

Parameters:
- LED_COUNT, 256, number of LEDs per strip; valid indices are 0..LED_COUNT-1.
- ADDR_WIDTH, 9, width of write_address; it matches the memory address port.
- SYNC_STAGES, 2, number of synchroniser flops on spi_sclk, spi_mosi and spi_cs_n; minimum 2.

Ports:
- clock_12mhz  input  1  system clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- spi_sclk  input  1  SPI clock, asynchronous; must be ≤ 3 MHz, with each phase at least 2 clock_12mhz periods.
- spi_mosi  input  1  SPI data; sampled on the synchronised rising edge of spi_sclk.
- spi_cs_n  input  1  SPI chip select, active low; frames one transaction.
- perform_write  output  1  one-cycle memory write strobe.
- write_address  output  ADDR_WIDTH  memory address; the upper bits beyond the index are zero.
- write_data  output  24  pixel word.
- frame_done  output  1  one-cycle pulse when a transaction ends cleanly.
- error  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset is asynchronous and active-low. Reset clears the following:
  - perform_write, frame_done and error to 0;
  - write_address and write_data to 0;
  - the synchronisers to idle levels (sclk=0, cs_n=1, mosi=0);
  - the state machine to IDLE.
- Reset asserted mid-transaction aborts it immediately. No write or pulse is issued for the aborted transaction.
- All SPI inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronised samples.
- Bit shifting:
  - Each detected sclk rising edge while cs_n is low shifts synchronised mosi into an 8-bit shift register, MSB first.
  - A 3-bit counter counts bits; the byte is complete at count 7 and the counter wraps to 0.
- State machine:
  - IDLE: on a cs_n falling edge, clear the bit counter and go to ADDR.
  - ADDR: on the first complete byte, capture it as the start index.
    - If index < LED_COUNT, load the address counter and go to PIXEL with byte slot 0.
    - Otherwise pulse error and go to DISCARD.
  - PIXEL: complete bytes fill slots 0, 1, 2 in the order R, G, B.
    - On completing slot 2, in the next cycle drive write_data/write_address and assert perform_write for exactly 1 cycle.
    - The address counter then increments. From LED_COUNT-1 it wraps to 0.
    - Write latency is 1 cycle after the detected edge completing bit 24 (SYNC_STAGES+2 cycles from the pin edge).
  - DISCARD: ignore all sclk edges.
- Ending a transaction (cs_n rising edge):
  - From PIXEL, always go to IDLE.
  - If the triple is complete (slot 0 pending), pulse frame_done 1 cycle later.
  - If 1–23 bits of the current triple were received, discard the partial triple: no write, pulse error instead of frame_done.
  - From ADDR with no complete byte, go to IDLE and pulse error.
  - From DISCARD, go to IDLE with no further pulse.
- A cs_n rising edge in the same cycle as a byte-completing sclk edge: the edge is applied first, then the deassert is evaluated.
- write_address and write_data hold their last written values between writes.
- frame_done and error never assert in the same cycle.
- There is no back-pressure: the memory write port accepts one write per cycle. Writes are at most 1 per 24 sclk periods.

Optional Feature:
- Macro RGB_TO_GRB_EN.
- When defined: write_data = {G, R, B}, i.e. the slot1 byte in [23:16], slot0 in [15:8], slot2 in [7:0]. This matches xx6812 wire order, so hosts send RGB.
- When undefined: write_data = {slot0, slot1, slot2}, as received. The host must send GRB.
- No other behaviour differs.

Test Plan:
- Index 0x05, then bytes 0x11,0x22,0x33, then cs_n high -> one perform_write, address 5, data 0x112233 (or 0x221133 with RGB_TO_GRB_EN), then frame_done pulse; error stays 0.
- Index 0xFF with LED_COUNT=256 and two triples -> writes at address 255 then 0 (wrap), followed by frame_done.
- Index 0x10 plus 16 extra bits, then cs_n high -> no write, single error pulse, no frame_done; state returns to IDLE and the next clean transaction works.
- LED_COUNT=100, index 100 -> error pulse after the index byte; no writes for the remaining 48 bits; no pulse at cs_n rise.
- reset_n low after 12 pixel bits -> outputs 0 asynchronously; after release, a new transaction with index 0x01 and 0xAABBCC writes 0xAABBCC at address 1 with no corruption.
- sclk at 3 MHz over 3 back-to-back triples -> three perform_write pulses each exactly 1 cycle wide, addresses incrementing by 1, and write latency of SYNC_STAGES+2 cycles from the 24th pin rising edge.
